ifu_align: RTL and testbench

Instruction aligner between the instruction-memory fetch port and the instruction decompressor in the IFU. It accepts naturally aligned 32-bit fetch words, buffers them as a halfword queue, and emits one instruction per handshake, either 16-bit (compressed) or 32-bit, with its PC. 32-bit instructions that straddle a word boundary are handled. Redirects (branch/jump/trap) flush the queue and may target a halfword-aligned PC.

---
 rtl/ifu_align.sv | 89 ++++++++
 tb/tb_ifu_align.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ifu_align.sv
// Instruction aligner: buffers 32-bit fetch words as a 3-entry halfword queue
// and emits one 16-bit or 32-bit instruction per handshake with its PC.
module ifu_align #(
  parameter int unsigned          XLEN     = 64,
  parameter logic [XLEN-1:0]      RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  input  logic [31:0]     fetch_data,
  output logic            fetch_ready,
  output logic            instr_valid,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc
);

  logic [15:0]     hq_q [3];
  logic [15:0]     hq_d [3];
  logic [1:0]      count_q, count_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;

  logic            head_c;
  logic            cons, acc;
  logic [1:0]      ncons, rem;

  // All outputs are functions of registered state only.
  always_comb begin
    head_c      = (hq_q[0][1:0] != 2'b11);
    instr_valid = ((count_q != 2'd0) && head_c) || ((count_q >= 2'd2) && !head_c);
    fetch_ready = (count_q <= 2'd1);
    instr_data  = head_c ? {16'h0000, hq_q[0]} : {hq_q[1], hq_q[0]};
    instr_pc    = pc_q;
  end

  always_comb begin
    cons  = instr_valid && instr_ready;
    acc   = fetch_valid && fetch_ready;
    ncons = cons ? (head_c ? 2'd1 : 2'd2) : 2'd0;
    rem   = count_q - ncons;

    // Shift the head out first; entries at or beyond rem are don't-care.
    case (ncons)
      2'd1:    hq_d = '{hq_q[1], hq_q[2], hq_q[2]};
      2'd2:    hq_d = '{hq_q[2], hq_q[2], hq_q[2]};
      default: hq_d = hq_q;
    endcase

    count_d = rem;
    drop_d  = drop_q;
    pc_d    = pc_q + XLEN'({ncons, 1'b0});

    // Accept only happens with count<=1, so rem<=1 and rem+1 stays in range.
    if (acc) begin
      if (drop_q) begin
        hq_d[rem] = fetch_data[31:16];
        count_d   = rem + 2'd1;
        drop_d    = 1'b0;
      end else begin
        hq_d[rem]         = fetch_data[15:0];
        hq_d[rem + 2'd1]  = fetch_data[31:16];
        count_d           = rem + 2'd2;
      end
    end

    if (flush) begin
      count_d = '0;
      pc_d    = flush_pc & ~XLEN'(1);
      drop_d  = flush_pc[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
    hq_q <= hq_d;
  end

endmodule

// File: tb/tb_ifu_align.sv
// Directed table-driven bench for ifu_align plus a compressed-stream throughput run.
module tb_ifu_align;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_data = '0;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [63:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] flush_pc = '0;

  int checks = 0;
  int failures = 0;

  ifu_align #(.XLEN(64), .RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .fetch_ready(fetch_ready),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .flush      (flush),
    .flush_pc   (flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [63:0] fpc;
    logic        fv;
    logic [31:0] fd;
    logic        ir;
    logic        chk;
    logic        iv;
    logic        fr;
    logic        chkd;
    logic [31:0] d;
    logic [63:0] pc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic fl, input logic [63:0] fpc,
                     input logic fv, input logic [31:0] fd, input logic ir,
                     input logic chk, input logic iv, input logic fr,
                     input logic chkd, input logic [31:0] d, input logic [63:0] pc);
    vec_t v;
    v.rst = r; v.fl = fl; v.fpc = fpc; v.fv = fv; v.fd = fd; v.ir = ir;
    v.chk = chk; v.iv = iv; v.fr = fr; v.chkd = chkd; v.d = d; v.pc = pc;
    vt.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  initial begin
    // Each row: inputs applied for one cycle; expected outputs observed in that same cycle.
    //  rst fl fpc                   fv fd            ir chk iv fr chkd d             pc
    add(1, 0, '0,                    0, '0,           0, 0, 0, 0, 0, '0,           '0);
    // Aligned 32-bit word
    add(0, 0, '0,                    1, 32'h00A00513, 1, 1, 0, 1, 0, '0,           RPC);
    add(0, 0, '0,                    0, '0,           1, 1, 1, 0, 1, 32'h00A00513, RPC);
    add(0, 0, '0,                    0, '0,           1, 1, 0, 1, 0, '0,           RPC + 4);
    // Two compressed in one word
    add(1, 0, '0,                    0, '0,           0, 1, 0, 1, 0, '0,           RPC + 4);
    add(0, 0, '0,                    1, 32'h45014505, 1, 1, 0, 1, 0, '0,           RPC);
    add(0, 0, '0,                    0, '0,           1, 1, 1, 0, 1, 32'h00004505, RPC);
    add(0, 0, '0,                    0, '0,           1, 1, 1, 1, 1, 32'h00004501, RPC + 2);
    add(0, 0, '0,                    0, '0,           1, 1, 0, 1, 0, '0,           RPC + 4);
    // Straddling 32-bit instruction
    add(1, 0, '0,                    0, '0,           0, 1, 0, 1, 0, '0,           RPC + 4);
    add(0, 0, '0,                    1, 32'h05134505, 1, 1, 0, 1, 0, '0,           RPC);
    add(0, 0, '0,                    0, '0,           1, 1, 1, 0, 1, 32'h00004505, RPC);
    add(0, 0, '0,                    0, '0,           1, 1, 0, 1, 0, '0,           RPC + 2);
    add(0, 0, '0,                    1, 32'h000000A0, 1, 1, 0, 1, 0, '0,           RPC + 2);
    add(0, 0, '0,                    0, '0,           1, 1, 1, 0, 1, 32'h00A00513, RPC + 2);
    add(0, 0, '0,                    0, '0,           1, 1, 1, 1, 1, 32'h00000000, RPC + 6);
    add(0, 0, '0,                    0, '0,           0, 1, 0, 1, 0, '0,           RPC + 8);
    // Flush at count=3 with a concurrent fetch and consume
    add(1, 0, '0,                    0, '0,           0, 1, 0, 1, 0, '0,           RPC + 8);
    add(0, 0, '0,                    1, 32'h05134505, 0, 1, 0, 1, 0, '0,           RPC);
    add(0, 0, '0,                    0, '0,           1, 1, 1, 0, 1, 32'h00004505, RPC);
    add(0, 0, '0,                    1, 32'h000000A0, 0, 1, 0, 1, 0, '0,           RPC + 2);
    add(0, 1, 64'h0000_0000_8000_0102, 1, 32'hDEADBEEF, 1, 1, 1, 0, 1, 32'h00A00513, RPC + 2);
    add(0, 0, '0,                    1, 32'h45014505, 1, 1, 0, 1, 0, '0,           64'h0000_0000_8000_0102);
    add(0, 0, '0,                    0, '0,           1, 1, 1, 1, 1, 32'h00004501, 64'h0000_0000_8000_0102);
    add(0, 0, '0,                    0, '0,           0, 1, 0, 1, 0, '0,           64'h0000_0000_8000_0104);
    // Odd flush target: bit0 ignored, bit1 sets drop; PC wraps past all-ones
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, '0,         0, 1, 0, 1, 0, '0,           64'h0000_0000_8000_0104);
    add(0, 0, '0,                    1, 32'h45050000, 1, 1, 0, 1, 0, '0,           64'hFFFF_FFFF_FFFF_FFFE);
    add(0, 0, '0,                    0, '0,           1, 1, 1, 1, 1, 32'h00004505, 64'hFFFF_FFFF_FFFF_FFFE);
    add(0, 0, '0,                    0, '0,           0, 1, 0, 1, 0, '0,           64'h0);
    // Backpressure for 5 cycles with fetch_valid held
    add(1, 0, '0,                    0, '0,           0, 1, 0, 1, 0, '0,           64'h0);
    add(0, 0, '0,                    1, 32'h45014505, 0, 1, 0, 1, 0, '0,           RPC);
    add(0, 0, '0,                    1, 32'h00A00513, 0, 1, 1, 0, 1, 32'h00004505, RPC);
    add(0, 0, '0,                    1, 32'h00A00513, 0, 1, 1, 0, 1, 32'h00004505, RPC);
    add(0, 0, '0,                    1, 32'h00A00513, 0, 1, 1, 0, 1, 32'h00004505, RPC);
    add(0, 0, '0,                    1, 32'h00A00513, 0, 1, 1, 0, 1, 32'h00004505, RPC);
    add(0, 0, '0,                    1, 32'h00A00513, 1, 1, 1, 0, 1, 32'h00004505, RPC);
    add(0, 0, '0,                    1, 32'h00A00513, 1, 1, 1, 1, 1, 32'h00004501, RPC + 2);
    add(0, 0, '0,                    0, '0,           1, 1, 1, 0, 1, 32'h00A00513, RPC + 4);
    add(0, 0, '0,                    0, '0,           0, 1, 0, 1, 0, '0,           RPC + 8);
    // Reset overrides a concurrent flush
    add(0, 0, '0,                    1, 32'h00A00513, 0, 1, 0, 1, 0, '0,           RPC + 8);
    add(1, 1, 64'h0000_0000_8000_0102, 0, '0,         1, 1, 1, 0, 1, 32'h00A00513, RPC + 8);
    add(0, 0, '0,                    0, '0,           0, 1, 0, 1, 0, '0,           RPC);

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rst; flush = vt[i].fl; flush_pc = vt[i].fpc;
      fetch_valid = vt[i].fv; fetch_data = vt[i].fd; instr_ready = vt[i].ir;
      #1;
      if (vt[i].chk) begin
        cmp($sformatf("v%0d instr_valid", i), 64'(instr_valid), 64'(vt[i].iv));
        cmp($sformatf("v%0d fetch_ready", i), 64'(fetch_ready), 64'(vt[i].fr));
        cmp($sformatf("v%0d instr_pc", i), instr_pc, vt[i].pc);
        if (vt[i].chkd)
          cmp($sformatf("v%0d instr_data", i), 64'(instr_data), 64'(vt[i].d));
      end
    end

    // Compressed-only stream: one instruction per cycle, fetch accepted every other cycle.
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; fetch_valid = 1'b1; fetch_data = 32'h45014505; instr_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      cmp($sformatf("stream%0d instr_valid", k), 64'(instr_valid), 64'(k >= 1));
      cmp($sformatf("stream%0d fetch_ready", k), 64'(fetch_ready), 64'((k == 0) || (k % 2 == 0)));
      if (k >= 1) begin
        cmp($sformatf("stream%0d instr_data", k), 64'(instr_data),
            (k % 2 == 1) ? 64'h4505 : 64'h4501);
        cmp($sformatf("stream%0d instr_pc", k), instr_pc, RPC + 64'(2 * (k - 1)));
      end
    end
    @(negedge clk);
    fetch_valid = 1'b0; instr_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
